// File: rtl/qif_neuron_scheduler.sv
// qif_neuron_scheduler
// Time-multiplexes N_NEUR quadratic integrate-and-fire neurons over one
// update datapath. A tick starts a sweep that updates one neuron per cycle;
// neurons that cross threshold push their id into a 4-entry spike FIFO.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   tick                 sweep request (ignored while busy)
//   cfg_we/addr/data     write synaptic current I[addr] (addr >= N_NEUR ignored)
//   v_mem_out/v_id/v_valid  membrane value written back this cycle
//   busy, sweep_done     sweep in progress / one-cycle end-of-sweep pulse
//   spk_valid/spk_id/spk_ready  spike FIFO head and pop handshake
//   ovf, tick_miss       sticky: spike dropped / tick ignored while busy
module qif_neuron_scheduler #(
   parameter int               N_NEUR  = 4,
   parameter logic signed [7:0] V_TH    = 8'sd50,
   parameter logic signed [7:0] V_RESET = -8'sd20,
   parameter int               REFRAC  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       cfg_we,
   input  logic [2:0] cfg_addr,
   input  logic [7:0] cfg_data,
   output logic [7:0] v_mem_out,
   output logic [2:0] v_id,
   output logic       v_valid,
   output logic       busy,
   output logic       sweep_done,
   output logic       spk_valid,
   output logic [2:0] spk_id,
   input  logic       spk_ready,
   output logic       ovf,
   output logic       tick_miss
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [2:0] LAST_IDX = 3'(N_NEUR - 1);
   localparam logic [3:0] N_L      = 4'(N_NEUR);

   state_t            state, state_nx;
   logic [2:0]        idx;

   // Per-neuron state; sized for the largest N_NEUR so a 3-bit index is exact.
   logic signed [7:0] v_mem [0:7];
   logic [7:0]        i_syn [0:7];
   logic [3:0]        r_cnt [0:7];

   logic [2:0]        fifo_mem [0:3];
   logic [1:0]        wr_ptr, rd_ptr;
   logic [2:0]        fifo_cnt;

   logic signed [7:0]  v_cur, v_sat, v_new;
   logic [7:0]         i_cur;
   logic [3:0]         r_cur, r_new;
   logic signed [11:0] v_ext, q_ext, sum_ext;
   logic               run, fire, push, pop, full, push_ok, cfg_ok;

   function automatic logic signed [7:0] sat8(input logic signed [11:0] x);
      if (x > 12'sd127)
         return 8'sd127;
      else if (x < -12'sd128)
         return -8'sd128;
      else
         return x[7:0];
   endfunction

   assign run   = (state == RUN);
   assign v_cur = v_mem[idx];
   assign i_cur = i_syn[idx];
   assign r_cur = r_cnt[idx];

   // 12-bit signed headroom: worst case 127 + 63 + 15*15 = 415.
   assign v_ext   = {{4{v_cur[7]}}, v_cur};
   assign q_ext   = v_ext >>> 3;
   assign sum_ext = v_ext + $signed({6'b0, i_cur[7:2]}) + q_ext * q_ext;
   assign v_sat   = sat8(sum_ext);

   assign fire  = (r_cur == 4'd0) && (v_sat >= V_TH);
   assign v_new = ((r_cur != 4'd0) || fire) ? V_RESET : v_sat;
   assign r_new = (r_cur != 4'd0) ? (r_cur - 4'd1) : (fire ? 4'(REFRAC) : 4'd0);

   assign push    = run && fire;
   assign pop     = (fifo_cnt != 3'd0) && spk_ready;
   assign full    = (fifo_cnt == 3'd4);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok = push && (!full || pop);
   assign cfg_ok  = ({1'b0, cfg_addr} < N_L);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (tick) state_nx = RUN;
         RUN:     if (idx == LAST_IDX) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= 3'd0;
         tick_miss <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= run ? (idx + 3'd1) : 3'd0;
         if (tick && (state != IDLE))
            tick_miss <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            v_mem[i] <= 8'sd0;
            i_syn[i] <= 8'd0;
            r_cnt[i] <= 4'd0;
         end
      end else begin
         if (run) begin
            v_mem[idx] <= v_new;
            r_cnt[idx] <= r_new;
         end
         if (cfg_we && cfg_ok)
            i_syn[cfg_addr] <= cfg_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
         ovf      <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 2'd1;
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         fifo_cnt <= fifo_cnt + {2'b0, push_ok} - {2'b0, pop};
         if (push && !push_ok)
            ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok)
         fifo_mem[wr_ptr] <= idx;
   end

   assign v_valid    = run;
   assign v_id       = run ? idx : 3'd0;
   assign v_mem_out  = run ? v_new : 8'd0;
   assign busy       = (state != IDLE);
   assign sweep_done = (state == DONE);
   assign spk_valid  = (fifo_cnt != 3'd0);
   assign spk_id     = spk_valid ? fifo_mem[rd_ptr] : 3'd0;

endmodule

// File: tb/tb_qif_neuron_scheduler.sv
// Testbench for qif_neuron_scheduler: sweep-level reference model feeding a
// scoreboard of expected write-backs, plus a spike FIFO model checked each cycle.
module tb_qif_neuron_scheduler;

   localparam int N  = 4;
   localparam int TH = 50;
   localparam int VR = -20;
   localparam int RF = 2;

   logic       clk = 1'b0;
   logic       rst_n, tick, cfg_we, spk_ready;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [7:0] v_mem_out;
   logic [2:0] v_id, spk_id;
   logic       v_valid, busy, sweep_done, spk_valid, ovf, tick_miss;

   qif_neuron_scheduler dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we),
      .cfg_addr(cfg_addr), .cfg_data(cfg_data), .v_mem_out(v_mem_out),
      .v_id(v_id), .v_valid(v_valid), .busy(busy), .sweep_done(sweep_done),
      .spk_valid(spk_valid), .spk_id(spk_id), .spk_ready(spk_ready),
      .ovf(ovf), .tick_miss(tick_miss)
   );

   always #5 clk = ~clk;

   typedef struct {int id; int v; bit spk;} upd_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   mV [N];
   int   mI [N];
   int   mR [N];
   upd_t exp_v [$];
   int   mfifo [$];
   bit   exp_ovf, exp_miss, rnd_ready;

   bit   mon_pop, mon_full;
   upd_t mon_e;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One full sweep computed from the neuron rules with plain integers.
   task automatic model_sweep();
      for (int k = 0; k < N; k++) begin
         upd_t u;
         u.id  = k;
         u.spk = 1'b0;
         if (mR[k] != 0) begin
            mV[k] = VR;
            mR[k] = mR[k] - 1;
         end else begin
            int q, s;
            q = mV[k] >>> 3;
            s = mV[k] + mI[k] / 4 + q * q;
            if (s > 127) s = 127;
            if (s < -128) s = -128;
            if (s >= TH) begin
               mV[k] = VR;
               mR[k] = RF;
               u.spk = 1'b1;
            end else begin
               mV[k] = s;
            end
         end
         u.v = mV[k];
         exp_v.push_back(u);
      end
   endtask

   // Monitor: pops expected write-backs and tracks the spike FIFO.
   always @(negedge clk) begin
      if (rst_n) begin
         mon_full = (mfifo.size() == 4);
         mon_pop  = (mfifo.size() > 0) && spk_ready;
         check("spk_valid", int'(spk_valid), int'(mfifo.size() > 0));
         if (mfifo.size() > 0)
            check("spk_id", int'(spk_id), mfifo[0]);
         if (mon_pop)
            void'(mfifo.pop_front());
         if (v_valid) begin
            if (exp_v.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL v_valid: unexpected strobe id %0d value %0d", v_id, $signed(v_mem_out));
            end else begin
               mon_e = exp_v.pop_front();
               check("v_id", int'(v_id), mon_e.id);
               check("v_mem_out", int'($signed(v_mem_out)), mon_e.v);
               if (mon_e.spk) begin
                  if (!mon_full || mon_pop) mfifo.push_back(mon_e.id);
                  else exp_ovf = 1'b1;
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) spk_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      #1;
      check("rst_busy", int'(busy), 0);
      check("rst_v_valid", int'(v_valid), 0);
      check("rst_spk_valid", int'(spk_valid), 0);
      check("rst_sweep_done", int'(sweep_done), 0);
      check("rst_ovf", int'(ovf), 0);
      check("rst_tick_miss", int'(tick_miss), 0);
      tick = 1'b0;
      cfg_we = 1'b0;
      spk_ready = 1'b0;
      rnd_ready = 1'b0;
      exp_v.delete();
      mfifo.delete();
      for (int k = 0; k < N; k++) begin
         mV[k] = 0; mI[k] = 0; mR[k] = 0;
      end
      exp_ovf = 1'b0;
      exp_miss = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic cfg_write(input int addr, input int data);
      cfg_we = 1'b1;
      cfg_addr = 3'(addr);
      cfg_data = 8'(data);
      step();
      cfg_we = 1'b0;
      if (addr < N) mI[addr] = data & 255;
   endtask

   // rdy_run: -1 leaves spk_ready alone, otherwise drives it from the first RUN cycle.
   task automatic do_sweep(input int rdy_run);
      tick = 1'b1;
      model_sweep();
      step();
      tick = 1'b0;
      if (rdy_run >= 0) spk_ready = 1'(rdy_run);
      check("busy_run", int'(busy), 1);
      repeat (N - 1) step();
      check("sweep_done_early", int'(sweep_done), 0);
      step();
      check("sweep_done", int'(sweep_done), 1);
      check("busy_done", int'(busy), 1);
      step();
      check("busy_idle", int'(busy), 0);
      check("all_strobes_seen", exp_v.size(), 0);
   endtask

   task automatic check_flags();
      check("ovf", int'(ovf), int'(exp_ovf));
      check("tick_miss", int'(tick_miss), int'(exp_miss));
   endtask

   task automatic drain();
      spk_ready = 1'b1;
      repeat (6) step();
      spk_ready = 1'b0;
      step();
   endtask

   initial begin
      rst_n = 1'b1; tick = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0;
      cfg_data = 8'd0; spk_ready = 1'b0; rnd_ready = 1'b0;
      #2;
      reset_dut();
      check_flags();

      // Single strong input on neuron 1
      cfg_write(1, 200);
      do_sweep(-1);
      check("spike_id1_present", int'(spk_valid), 1);
      drain();
      check_flags();

      // Integration trajectory, refractory and one spike on neuron 0
      reset_dut();
      spk_ready = 1'b1;
      cfg_write(0, 40);
      repeat (7) do_sweep(-1);
      check_flags();

      // Overflow: all neurons spike with no consumer
      reset_dut();
      for (int k = 0; k < N; k++) cfg_write(k, 255);
      repeat (4) do_sweep(-1);
      check("ovf_set", int'(ovf), 1);
      check_flags();
      drain();

      // Full FIFO, simultaneous push and pop
      reset_dut();
      for (int k = 0; k < N; k++) cfg_write(k, 255);
      do_sweep(-1);
      do_sweep(-1);
      do_sweep(-1);
      do_sweep(1);
      spk_ready = 1'b0;
      check_flags();
      drain();

      // Back-to-back ticks: second is missed
      reset_dut();
      cfg_write(2, 120);
      tick = 1'b1;
      model_sweep();
      step();
      exp_miss = 1'b1;
      step();
      tick = 1'b0;
      repeat (N + 2) step();
      check("miss_strobes_seen", exp_v.size(), 0);
      check_flags();
      drain();

      // Reset in the middle of a sweep, then a clean sweep from zero
      reset_dut();
      cfg_write(0, 100);
      cfg_write(3, 90);
      tick = 1'b1;
      model_sweep();
      step();
      tick = 1'b0;
      step();
      reset_dut();
      do_sweep(-1);
      check_flags();

      // Randomized traffic with a random consumer
      reset_dut();
      rnd_ready = 1'b1;
      for (int it = 0; it < 30; it++) begin
         int nw;
         nw = $urandom_range(0, 2);
         for (int w = 0; w < nw; w++) cfg_write($urandom_range(0, 7), $urandom_range(0, 255));
         do_sweep(-1);
         repeat ($urandom_range(0, 2)) step();
      end
      rnd_ready = 1'b0;
      check_flags();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/qif_neuron_scheduler.md
QIF_NEURON_SCHEDULER -- requirements
Module: qif_neuron_scheduler

Interface
REQ-001 Parameter N_NEUR, default 4, number of virtual neurons time-multiplexed on one QIF update datapath (2..8).
REQ-002 Parameter V_TH, default 8'sd50, spike threshold (signed).
REQ-003 Parameter V_RESET, default -8'sd20, post-spike membrane value (signed).
REQ-004 Parameter REFRAC, default 2, refractory length in sweeps (0..15).
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous assert, active low.
REQ-007 tick  in  1  sweep request, sampled each cycle.
REQ-008 cfg_we  in  1  write strobe for synaptic current register.
REQ-009 cfg_addr  in  3  neuron index for cfg write; indices >= N_NEUR are ignored.
REQ-010 cfg_data  in  8  unsigned synaptic current I_syn.
REQ-011 v_mem_out  out  8  signed membrane value written back this cycle.
REQ-012 v_id  out  3  neuron index of v_mem_out.
REQ-013 v_valid  out  1  one-cycle strobe qualifying v_mem_out/v_id.
REQ-014 busy  out  1  high while a sweep is in progress.
REQ-015 sweep_done  out  1  one-cycle pulse at sweep end.
REQ-016 spk_valid, spk_id  out  1, 3  head of spike event FIFO.
REQ-017 spk_ready  in  1  consumer pop; pop occurs when spk_valid & spk_ready.
REQ-018 ovf, tick_miss  out  1, 1  sticky flags: spike dropped; tick ignored while busy.

Function
REQ-019 State per neuron: signed 8-bit V, unsigned 8-bit I, 4-bit refractory count R.
REQ-020 FSM states: IDLE, RUN, DONE; IDLE->RUN on tick (idx<=0); RUN advances idx each cycle; RUN->DONE after idx N_NEUR-1; DONE->IDLE unconditionally.
REQ-021 Latency: tick high in cycle t -> neuron k written at edge ending cycle t+1+k; sweep_done high in cycle t+1+N_NEUR; busy high in RUN and DONE.
REQ-022 Update when R==0: sum = V + (I>>2) + q*q, q = V>>>3 (arithmetic), computed at >=11-bit signed, saturated to [-128,127].
REQ-023 If saturated sum >= V_TH: V<=V_RESET, R<=REFRAC, spike event pushed with id idx; else V<=sum.
REQ-024 If R!=0: V<=V_RESET, R<=R-1, no integration, no spike.
REQ-025 Each RUN cycle drives v_valid=1, v_id=idx, v_mem_out=new V of that neuron; v_valid=0 otherwise.
REQ-026 cfg write updates I[cfg_addr] at clock edge; a RUN update in the same cycle for that neuron uses pre-edge I.
REQ-027 tick while busy: ignored, tick_miss<=1; tick in DONE cycle also ignored.
REQ-028 Spike FIFO: depth 4, in order, spk_valid = not empty, spk_id = oldest entry.
REQ-029 Full and push without pop: event dropped, ovf<=1; full with push and pop same cycle: both occur, count unchanged.
REQ-030 Empty with push: spk_valid rises the next cycle (no fall-through).
REQ-031 ovf and tick_miss clear only on reset.

Reset
REQ-032 rst_n low: immediately state IDLE, all V=0, I=0, R=0, FIFO empty, all outputs 0, flags 0.
REQ-033 Reset mid-sweep aborts the sweep; no partial write or spike survives; first tick after release starts a full sweep at idx 0.

Verification
REQ-034 Reset: assert rst_n mid-RUN -> busy=0, spk_valid=0, v_valid=0 same cycle; next sweep with I=0 writes V=0 for ids 0..3.
REQ-035 I[1]=200, one tick -> id1 v_mem_out=-20, spike id1 in FIFO, others 0; sweep_done at t+5.
REQ-036 I[0]=40, ticks 1..7 -> V0 = 10, 21, 35, spike(-20), -20, -20, -1; exactly one spike event id0.
REQ-037 I[0..3]=255, spk_ready=0, 4 sweeps -> FIFO holds 0,1,2,3 after sweep1; sweep4 spikes dropped, ovf=1.
REQ-038 FIFO full, push on same cycle as pop -> spk_id advances, count stays 4, ovf stays 0.
REQ-039 tick in cycles t and t+1 -> one sweep only, tick_miss=1, four v_valid strobes.
